// File: rtl/arm_dp_pkg.sv
// Shared constants for the ARM data-processing sequencer: opcodes, condition codes, NZCV bit
// positions and sequencer state encoding. Optional feature macro: DP_SEQ_COND_EXEC_EN.
package arm_dp_pkg;

   localparam int ARM_REG_ADDR_W = 5;
   localparam int ARM_OP_W       = 4;

   localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
                          OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
                          OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
                          OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

   localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
                          COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
                          COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
                          COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

   localparam int NZCV_N = 3;
   localparam int NZCV_Z = 2;
   localparam int NZCV_C = 1;
   localparam int NZCV_V = 0;

`ifdef DP_SEQ_COND_EXEC_EN
   localparam int ST_W = 3;
`else
   localparam int ST_W = 2;
`endif

   localparam logic [ST_W-1:0] ST_IDLE   = ST_W'(0);
   localparam logic [ST_W-1:0] ST_DECODE = ST_W'(1);
   localparam logic [ST_W-1:0] ST_EXEC   = ST_W'(2);
   localparam logic [ST_W-1:0] ST_WB     = ST_W'(3);
`ifdef DP_SEQ_COND_EXEC_EN
   localparam logic [ST_W-1:0] ST_SKIP   = ST_W'(4);
`endif

   // TST/TEQ/CMP/CMN: always update flags, never write a register
   function automatic logic is_test_op(input logic [3:0] op);
      return (op[3:2] == 2'b10);
   endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluator against the current NZCV flags.
module cond_check
   import arm_dp_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [3:0] nzcv_i,
   output logic       pass_o
);

   logic n, z, c, v;

   assign n = nzcv_i[NZCV_N];
   assign z = nzcv_i[NZCV_Z];
   assign c = nzcv_i[NZCV_C];
   assign v = nzcv_i[NZCV_V];

   always_comb begin
      pass_o = 1'b0;
      case (cond_i)
         COND_EQ: pass_o = z;
         COND_NE: pass_o = !z;
         COND_CS: pass_o = c;
         COND_CC: pass_o = !c;
         COND_MI: pass_o = n;
         COND_PL: pass_o = !n;
         COND_VS: pass_o = v;
         COND_VC: pass_o = !v;
         COND_HI: pass_o = c && !z;
         COND_LS: pass_o = !c || z;
         COND_GE: pass_o = (n == v);
         COND_LT: pass_o = (n != v);
         COND_GT: pass_o = !z && (n == v);
         COND_LE: pass_o = z || (n != v);
         COND_AL: pass_o = 1'b1;
         default: pass_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/dp_sequencer.sv
// Sequences one ARM data-processing command through DECODE/EXEC/WB and owns the NZCV register.
// Optional feature macro: DP_SEQ_COND_EXEC_EN (conditional execution with SKIP state).
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// DECODE | operands addressed, condition evaluated
// EXEC   | ALU settling, flags captured on exit
// WB     | register write (unless compare/test op), done pulse
// SKIP   | condition failed, done + skipped, no write
module dp_sequencer
   import arm_dp_pkg::*;
#(
   parameter int REG_ADDR_W = ARM_REG_ADDR_W,
   parameter int OP_W       = ARM_OP_W
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [OP_W-1:0]       cmd_opcode_i,
   input  logic [REG_ADDR_W-1:0] cmd_rn_i,
   input  logic [REG_ADDR_W-1:0] cmd_rm_i,
   input  logic [REG_ADDR_W-1:0] cmd_rd_i,
   input  logic                  cmd_set_flags_i,
   input  logic [3:0]            cmd_cond_i,
   output logic [REG_ADDR_W-1:0] read_reg_num1_o,
   output logic [REG_ADDR_W-1:0] read_reg_num2_o,
   output logic [REG_ADDR_W-1:0] write_reg_o,
   output logic [OP_W-1:0]       alu_control_o,
   output logic                  regwrite_o,
   input  logic                  zero_flag_i,
   input  logic                  carry_flag_i,
   input  logic                  overflow_flag_i,
   input  logic                  negative_flag_i,
   output logic [3:0]            nzcv_o,
   output logic                  done_o,
   output logic                  skipped_o,
   output logic                  busy_o
);

   logic [ST_W-1:0]       state_q, state_d;
   logic [OP_W-1:0]       op_q;
   logic [REG_ADDR_W-1:0] rn_q, rm_q, rd_q;
   logic                  set_flags_q;
   logic [3:0]            nzcv_q;
   logic                  accept;
   logic                  flag_update;

   assign accept      = cmd_valid_i && (state_q == ST_IDLE);
   assign flag_update = (state_q == ST_EXEC) && (set_flags_q || is_test_op(op_q[3:0]));

`ifdef DP_SEQ_COND_EXEC_EN
   logic [3:0] cond_q;
   logic       cond_pass;

   cond_check u_cond_check (
      .cond_i (cond_q),
      .nzcv_i (nzcv_q),
      .pass_o (cond_pass)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)    cond_q <= 4'h0;
      else if (accept) cond_q <= cmd_cond_i;
   end

   assign skipped_o = (state_q == ST_SKIP);
`else
   logic unused_cond;
   assign unused_cond = ^cmd_cond_i;
   assign skipped_o   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (cmd_valid_i) state_d = ST_DECODE;
`ifdef DP_SEQ_COND_EXEC_EN
         ST_DECODE: state_d = cond_pass ? ST_EXEC : ST_SKIP;
         ST_SKIP:   state_d = ST_IDLE;
`else
         ST_DECODE: state_d = ST_EXEC;
`endif
         ST_EXEC:   state_d = ST_WB;
         ST_WB:     state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         rn_q        <= '0;
         rm_q        <= '0;
         rd_q        <= '0;
         set_flags_q <= 1'b0;
         nzcv_q      <= 4'b0000;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q        <= cmd_opcode_i;
            rn_q        <= cmd_rn_i;
            rm_q        <= cmd_rm_i;
            rd_q        <= cmd_rd_i;
            set_flags_q <= cmd_set_flags_i;
         end
         if (flag_update)
            nzcv_q <= {negative_flag_i, zero_flag_i, carry_flag_i, overflow_flag_i};
      end
   end

   // Control outputs come straight from the latched command so they hold through IDLE
   assign read_reg_num1_o = rn_q;
   assign read_reg_num2_o = rm_q;
   assign write_reg_o     = rd_q;
   assign alu_control_o   = op_q;
   assign regwrite_o      = (state_q == ST_WB) && !is_test_op(op_q[3:0]);
   assign nzcv_o          = nzcv_q;
   assign cmd_ready_o     = (state_q == ST_IDLE);
   assign busy_o          = (state_q != ST_IDLE);
`ifdef DP_SEQ_COND_EXEC_EN
   assign done_o          = (state_q == ST_WB) || (state_q == ST_SKIP);
`else
   assign done_o          = (state_q == ST_WB);
`endif

endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer: a behavioural register file/ALU stands in for the datapath,
// and a scoreboard predicts every retirement from an independent reference model.
module tb_dp_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [3:0]  cmd_opcode_i = '0;
   logic [4:0]  cmd_rn_i = '0, cmd_rm_i = '0, cmd_rd_i = '0;
   logic        cmd_set_flags_i = 1'b0;
   logic [3:0]  cmd_cond_i = '0;
   logic [4:0]  read_reg_num1_o, read_reg_num2_o, write_reg_o;
   logic [3:0]  alu_control_o;
   logic        regwrite_o;
   logic        zero_flag_i, carry_flag_i, overflow_flag_i, negative_flag_i;
   logic [3:0]  nzcv_o;
   logic        done_o, skipped_o, busy_o;

   always #5 clk_i = ~clk_i;

   dp_sequencer dut (
      .clk_i           (clk_i),
      .rst_n_i         (rst_n_i),
      .cmd_valid_i     (cmd_valid_i),
      .cmd_ready_o     (cmd_ready_o),
      .cmd_opcode_i    (cmd_opcode_i),
      .cmd_rn_i        (cmd_rn_i),
      .cmd_rm_i        (cmd_rm_i),
      .cmd_rd_i        (cmd_rd_i),
      .cmd_set_flags_i (cmd_set_flags_i),
      .cmd_cond_i      (cmd_cond_i),
      .read_reg_num1_o (read_reg_num1_o),
      .read_reg_num2_o (read_reg_num2_o),
      .write_reg_o     (write_reg_o),
      .alu_control_o   (alu_control_o),
      .regwrite_o      (regwrite_o),
      .zero_flag_i     (zero_flag_i),
      .carry_flag_i    (carry_flag_i),
      .overflow_flag_i (overflow_flag_i),
      .negative_flag_i (negative_flag_i),
      .nzcv_o          (nzcv_o),
      .done_o          (done_o),
      .skipped_o       (skipped_o),
      .busy_o          (busy_o)
   );

   typedef struct {
      int          cyc;
      logic        skip;
      logic        wr;
      logic [4:0]  rn, rm, rd;
      logic [3:0]  op;
      logic [3:0]  nzcv;
      logic [31:0] res;
   } exp_t;

   exp_t        sb[$];
   int          acc_cyc[$];
   int          checks = 0, errors = 0, cyc = 0;
   logic [31:0] dp_rf [32];
   logic [31:0] mdl_rf [32];
   logic [3:0]  mdl_nzcv = 4'b0000;
   logic        pre_we = 1'b0;
   logic [4:0]  pre_addr = '0;
   logic [31:0] pre_data = '0;
   logic [31:0] dp_res;

   // {N,Z,C,V,result}; carry-in variants are treated as their plain forms
   function automatic logic [35:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] r;
      logic        c, v;
      s = '0; r = '0; c = 1'b0; v = 1'b0;
      case (op)
         4'h0, 4'h8: r = a & b;
         4'h1, 4'h9: r = a ^ b;
         4'h2, 4'h6, 4'hA: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         4'h3, 4'h7: begin
            s = {1'b0, b} + {1'b0, ~a} + 33'd1; r = s[31:0]; c = s[32];
            v = (a[31] != b[31]) && (r[31] != b[31]);
         end
         4'h4, 4'h5, 4'hB: begin
            s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'hC: r = a | b;
         4'hD: r = b;
         4'hE: r = a & ~b;
         default: r = ~b;
      endcase
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   function automatic logic cond_ok(input logic [3:0] cd, input logic [3:0] f);
`ifdef DP_SEQ_COND_EXEC_EN
      logic fn, fz, fc, fv;
      fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
      case (cd)
         4'd0:  return fz;
         4'd1:  return !fz;
         4'd2:  return fc;
         4'd3:  return !fc;
         4'd4:  return fn;
         4'd5:  return !fn;
         4'd6:  return fv;
         4'd7:  return !fv;
         4'd8:  return fc & !fz;
         4'd9:  return !fc | fz;
         4'd10: return fn ~^ fv;
         4'd11: return fn ^ fv;
         4'd12: return !fz & (fn ~^ fv);
         4'd13: return fz | (fn ^ fv);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
`else
      return (cd == cd) || (f != f);
`endif
   endfunction

   // Datapath stand-in: combinational ALU on the addressed registers, write on regwrite
   always_comb begin
      {negative_flag_i, zero_flag_i, carry_flag_i, overflow_flag_i, dp_res} =
         alu(alu_control_o, dp_rf[read_reg_num1_o], dp_rf[read_reg_num2_o]);
   end

   always @(posedge clk_i) begin
      cyc <= cyc + 1;
      if (pre_we)          dp_rf[pre_addr] <= pre_data;
      else if (regwrite_o) dp_rf[write_reg_o] <= dp_res;
   end

   // Scoreboard: predict at acceptance, compare at retirement
   exp_t        e, p;
   logic [35:0] ar;
   logic        pass, tst;

   always @(negedge clk_i) begin
      if (rst_n_i) begin
         if (done_o) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: got done at cycle %0d, required no done", cyc);
            end else begin
               e = sb.pop_front();
               if (cyc !== e.cyc) begin
                  errors++;
                  $display("FAIL done_timing: got cycle %0d, required %0d", cyc, e.cyc);
               end
               checks++;
               if ({skipped_o, regwrite_o} !== {e.skip, e.wr}) begin
                  errors++;
                  $display("FAIL retire_ctrl: got skipped=%b regwrite=%b, required skipped=%b regwrite=%b",
                           skipped_o, regwrite_o, e.skip, e.wr);
               end
               checks++;
               if ({read_reg_num1_o, read_reg_num2_o, write_reg_o, alu_control_o} !== {e.rn, e.rm, e.rd, e.op}) begin
                  errors++;
                  $display("FAIL retire_addr: got rn=%0d rm=%0d rd=%0d op=%h, required rn=%0d rm=%0d rd=%0d op=%h",
                           read_reg_num1_o, read_reg_num2_o, write_reg_o, alu_control_o, e.rn, e.rm, e.rd, e.op);
               end
               checks++;
               if (nzcv_o !== e.nzcv) begin
                  errors++;
                  $display("FAIL retire_nzcv: got %b, required %b", nzcv_o, e.nzcv);
               end
               mdl_nzcv = e.nzcv;
               if (e.wr) mdl_rf[e.rd] = e.res;
            end
         end else begin
            checks++;
            if (regwrite_o !== 1'b0) begin
               errors++;
               $display("FAIL regwrite_outside_wb: got %b at cycle %0d, required 0", regwrite_o, cyc);
            end
         end
         if (sb.size() != 0 && cyc > sb[0].cyc) begin
            checks++; errors++;
            $display("FAIL missing_done: no retirement by cycle %0d, required at %0d", cyc, sb[0].cyc);
            void'(sb.pop_front());
         end
         if (cmd_valid_i && cmd_ready_o) begin
            ar   = alu(cmd_opcode_i, mdl_rf[cmd_rn_i], mdl_rf[cmd_rm_i]);
            pass = cond_ok(cmd_cond_i, mdl_nzcv);
            tst  = cmd_opcode_i inside {[4'h8:4'hB]};
            p.cyc  = cyc + 3;
            p.skip = !pass;
            p.wr   = pass && !tst;
            p.rn   = cmd_rn_i; p.rm = cmd_rm_i; p.rd = cmd_rd_i; p.op = cmd_opcode_i;
            p.nzcv = (pass && (cmd_set_flags_i || tst)) ? ar[35:32] : mdl_nzcv;
            p.res  = ar[31:0];
            sb.push_back(p);
            acc_cyc.push_back(cyc);
         end
      end
   end

   task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
      @(posedge clk_i); #1;
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clk_i); #1;
      pre_we = 1'b0;
      mdl_rf[a] = d;
   endtask

   task automatic drive_cmd(input logic [3:0] op, input logic [4:0] rn, input logic [4:0] rm,
                            input logic [4:0] rd, input logic s, input logic [3:0] cd);
      cmd_opcode_i = op; cmd_rn_i = rn; cmd_rm_i = rm; cmd_rd_i = rd;
      cmd_set_flags_i = s; cmd_cond_i = cd; cmd_valid_i = 1'b1;
   endtask

   task automatic send(input logic [3:0] op, input logic [4:0] rn, input logic [4:0] rm,
                       input logic [4:0] rd, input logic s, input logic [3:0] cd);
      int n;
      @(posedge clk_i); #1;
      drive_cmd(op, rn, rm, rd, s, cd);
      n = 0;
      do begin @(negedge clk_i); n++; end while (!cmd_ready_o && n < 20);
      checks++;
      if (!cmd_ready_o) begin
         errors++;
         $display("FAIL accept_timeout: cmd_ready stayed %b, required 1", cmd_ready_o);
      end
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0;
      cmd_opcode_i = 4'hF; cmd_rd_i = 5'd31; cmd_cond_i = 4'hF;
      n = 0;
      while (sb.size() != 0 && n < 20) begin @(negedge clk_i); n++; end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL retire_timeout: %0d commands pending, required 0", sb.size());
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 32; i++) set_reg(5'(i), 32'h100 + 32'(i));
      #1;
      checks++;
      if ({cmd_ready_o, busy_o, done_o, skipped_o, regwrite_o} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_status: got ready,busy,done,skip,we=%b, required 10000",
                  {cmd_ready_o, busy_o, done_o, skipped_o, regwrite_o});
      end
      checks++;
      if ({read_reg_num1_o, read_reg_num2_o, write_reg_o, alu_control_o, nzcv_o} !== 23'd0) begin
         errors++;
         $display("FAIL reset_ctrl: got rn=%0d rm=%0d rd=%0d op=%h nzcv=%b, required all 0",
                  read_reg_num1_o, read_reg_num2_o, write_reg_o, alu_control_o, nzcv_o);
      end
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
   endtask

   task automatic test_add();
      send(4'h4, 5'd1, 5'd2, 5'd3, 1'b0, 4'hE);
      checks++;
      if (dp_rf[3] !== 32'h203 || nzcv_o !== 4'b0000) begin
         errors++;
         $display("FAIL add: got r3=%h nzcv=%b, required r3=00000203 nzcv=0000", dp_rf[3], nzcv_o);
      end
   endtask

   task automatic test_subs_cmp();
      set_reg(5'd1, 32'd5);
      set_reg(5'd2, 32'd5);
      send(4'h2, 5'd1, 5'd2, 5'd5, 1'b1, 4'hE);
      checks++;
      if (dp_rf[5] !== 32'd0 || nzcv_o !== 4'b0110) begin
         errors++;
         $display("FAIL subs: got r5=%h nzcv=%b, required r5=0 nzcv=0110", dp_rf[5], nzcv_o);
      end
      send(4'h4, 5'd1, 5'd2, 5'd7, 1'b1, 4'hE);
      checks++;
      if (dp_rf[7] !== 32'd10 || nzcv_o !== 4'b0000) begin
         errors++;
         $display("FAIL adds: got r7=%h nzcv=%b, required r7=0000000a nzcv=0000", dp_rf[7], nzcv_o);
      end
      send(4'hA, 5'd4, 5'd4, 5'd6, 1'b0, 4'hE);
      checks++;
      if (dp_rf[6] !== 32'h106 || nzcv_o !== 4'b0110) begin
         errors++;
         $display("FAIL cmp: got r6=%h nzcv=%b, required r6=00000106 nzcv=0110", dp_rf[6], nzcv_o);
      end
   endtask

   task automatic test_cond();
      logic [31:0] want8;
`ifdef DP_SEQ_COND_EXEC_EN
      want8 = 32'h108;
`else
      want8 = 32'd10;
`endif
      send(4'h4, 5'd1, 5'd2, 5'd8, 1'b0, 4'h1);
      send(4'h4, 5'd1, 5'd2, 5'd9, 1'b0, 4'h0);
      checks++;
      if (dp_rf[8] !== want8 || dp_rf[9] !== 32'd10 || nzcv_o !== 4'b0110) begin
         errors++;
         $display("FAIL cond: got r8=%h r9=%h nzcv=%b, required r8=%h r9=0000000a nzcv=0110",
                  dp_rf[8], dp_rf[9], nzcv_o, want8);
      end
   endtask

   task automatic test_back_to_back();
      int n, rdy, base;
      base = acc_cyc.size();
      @(posedge clk_i); #1;
      drive_cmd(4'h4, 5'd10, 5'd1, 5'd10, 1'b0, 4'hE);
      n = 0; rdy = 0;
      while (rdy < 3 && n < 30) begin
         @(negedge clk_i); n++;
         if (cmd_ready_o) rdy++;
      end
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0;
      checks++;
      if (rdy != 3 || n != 9) begin
         errors++;
         $display("FAIL b2b_ready: got %0d ready cycles over %0d cycles, required 3 over 9", rdy, n);
      end
      n = 0;
      while (sb.size() != 0 && n < 20) begin @(negedge clk_i); n++; end
      @(posedge clk_i); #1;
      checks++;
      if (acc_cyc.size() != base + 3 || acc_cyc[base+1] - acc_cyc[base] != 4 || acc_cyc[base+2] - acc_cyc[base+1] != 4) begin
         errors++;
         $display("FAIL b2b_spacing: got %0d accepts, required 3 spaced by 4 cycles", acc_cyc.size() - base);
      end
      checks++;
      if (dp_rf[10] !== 32'h119) begin
         errors++;
         $display("FAIL b2b_accum: got r10=%h, required 00000119", dp_rf[10]);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      @(posedge clk_i); #1;
      drive_cmd(4'h4, 5'd1, 5'd2, 5'd11, 1'b1, 4'hE);
      n = 0;
      do begin @(negedge clk_i); n++; end while (!cmd_ready_o && n < 20);
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i); #2;
      rst_n_i = 1'b0;
      #1;
      sb.delete();
      mdl_nzcv = 4'b0000;
      checks++;
      if ({regwrite_o, busy_o, cmd_ready_o, done_o, nzcv_o} !== 8'b0010_0000) begin
         errors++;
         $display("FAIL reset_mid: got we,busy,ready,done=%b nzcv=%b, required 0010 nzcv=0000",
                  {regwrite_o, busy_o, cmd_ready_o, done_o}, nzcv_o);
      end
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      checks++;
      if (dp_rf[11] !== 32'h10B) begin
         errors++;
         $display("FAIL reset_mid_nowrite: got r11=%h, required 0000010b", dp_rf[11]);
      end
      send(4'h4, 5'd1, 5'd2, 5'd11, 1'b0, 4'hE);
      checks++;
      if (dp_rf[11] !== 32'd10 || nzcv_o !== 4'b0000) begin
         errors++;
         $display("FAIL reset_mid_after: got r11=%h nzcv=%b, required 0000000a 0000", dp_rf[11], nzcv_o);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         if (i % 3 == 0) set_reg(5'($urandom_range(1, 15)), $urandom);
         send(4'($urandom_range(15)), 5'($urandom_range(1, 15)), 5'($urandom_range(1, 15)),
              5'($urandom_range(1, 15)), 1'($urandom_range(1)), 4'($urandom_range(15)));
      end
      checks++;
      for (int i = 0; i < 32; i++) begin
         if (dp_rf[i] !== mdl_rf[i]) begin
            errors++;
            $display("FAIL random_rf: got r%0d=%h, required %h", i, dp_rf[i], mdl_rf[i]);
            break;
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_subs_cmp();
      test_cond();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
